// File: rtl/hdc_class_driver.sv
// Batch sequencer feeding a window stream through an HDC classifier (train or test).
// Define HDC_ACC_STATS_EN to add the correct_cnt accuracy counter output.
module hdc_class_driver #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  op,
    input  logic [CNT_W-1:0]      num_windows,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [DIMENSIONS-1:0] win_hv,
    input  logic                  win_label,
    output logic                  cls_en,
    output logic                  cls_op,
    output logic [DIMENSIONS-1:0] cls_window_hv,
    output logic                  cls_label_train,
    input  logic                  cls_done,
    input  logic                  cls_label_predict,
    output logic                  res_valid,
    output logic                  res_label,
    output logic [CNT_W-1:0]      res_index,
    output logic                  busy,
    output logic                  batch_done,
    output logic [CNT_W-1:0]      seizure_cnt
`ifdef HDC_ACC_STATS_EN
    ,
    output logic [CNT_W-1:0]      correct_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, REPORT} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        num_q, num_nxt;
    logic [CNT_W-1:0]        idx_q, idx_nxt;
    logic                    guard_q, guard_nxt;
    logic                    op_nxt;
    logic [DIMENSIONS-1:0]   hv_nxt;
    logic                    lbl_nxt;
    logic                    en_nxt;
    logic                    rdy_nxt;
    logic                    rv_nxt;
    logic                    rl_nxt;
    logic [CNT_W-1:0]        ri_nxt;
    logic                    busy_nxt;
    logic                    bd_nxt;
    logic [CNT_W-1:0]        sz_nxt;
`ifdef HDC_ACC_STATS_EN
    logic [CNT_W-1:0]        cc_nxt;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            num_q           <= '0;
            idx_q           <= '0;
            guard_q         <= 1'b0;
            cls_op          <= 1'b0;
            cls_window_hv   <= '0;
            cls_label_train <= 1'b0;
            cls_en          <= 1'b0;
            win_ready       <= 1'b0;
            res_valid       <= 1'b0;
            res_label       <= 1'b0;
            res_index       <= '0;
            busy            <= 1'b0;
            batch_done      <= 1'b0;
            seizure_cnt     <= '0;
`ifdef HDC_ACC_STATS_EN
            correct_cnt     <= '0;
`endif
        end else begin
            state           <= state_nxt;
            num_q           <= num_nxt;
            idx_q           <= idx_nxt;
            guard_q         <= guard_nxt;
            cls_op          <= op_nxt;
            cls_window_hv   <= hv_nxt;
            cls_label_train <= lbl_nxt;
            cls_en          <= en_nxt;
            win_ready       <= rdy_nxt;
            res_valid       <= rv_nxt;
            res_label       <= rl_nxt;
            res_index       <= ri_nxt;
            busy            <= busy_nxt;
            batch_done      <= bd_nxt;
            seizure_cnt     <= sz_nxt;
`ifdef HDC_ACC_STATS_EN
            correct_cnt     <= cc_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        num_nxt   = num_q;
        idx_nxt   = idx_q;
        guard_nxt = 1'b0;
        op_nxt    = cls_op;
        hv_nxt    = cls_window_hv;
        lbl_nxt   = cls_label_train;
        en_nxt    = 1'b0;
        rv_nxt    = 1'b0;
        rl_nxt    = res_label;
        ri_nxt    = res_index;
        busy_nxt  = busy;
        bd_nxt    = 1'b0;
        sz_nxt    = seizure_cnt;
`ifdef HDC_ACC_STATS_EN
        cc_nxt    = correct_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
                    op_nxt  = op;
                    num_nxt = num_windows;
                    idx_nxt = '0;
                    sz_nxt  = '0;
`ifdef HDC_ACC_STATS_EN
                    cc_nxt  = '0;
`endif
                    // An empty batch completes at once without leaving IDLE
                    if (num_windows == '0) begin
                        bd_nxt   = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        busy_nxt  = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (win_valid && win_ready) begin
                    hv_nxt    = win_hv;
                    lbl_nxt   = win_label;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cls_done) begin
                    en_nxt    = 1'b1;
                    guard_nxt = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // First WAIT cycle ignores cls_done: the classifier has not yet seen cls_en
                if (!guard_q && cls_done) begin
                    state_nxt = REPORT;
                    if (cls_op) begin
                        rv_nxt = 1'b1;
                        rl_nxt = cls_label_predict;
                        ri_nxt = idx_q;
                        if (cls_label_predict && (seizure_cnt != '1))
                            sz_nxt = seizure_cnt + CNT_W'(1);
`ifdef HDC_ACC_STATS_EN
                        if ((cls_label_predict == cls_label_train) && (correct_cnt != '1))
                            cc_nxt = correct_cnt + CNT_W'(1);
`endif
                    end
                end
            end
            REPORT: begin
                idx_nxt = idx_q + CNT_W'(1);
                if (idx_nxt == num_q) begin
                    bd_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        rdy_nxt = (state_nxt == FETCH);
    end

endmodule
